// File: rtl/stage2_pow2_approx.sv
// Softmax back-end stage: forms e = x*log2(e) - log2(sum) in Q10.10 and
// evaluates 2^e with Mitchell's inverse approximation into unsigned Q1.15.
// Three enable-gated register stages (S0, S1, S2), same style as the log2 stage.
module stage2_pow2_approx (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic        i_valid,
  input  logic [15:0] i_log2_sum,
  input  logic [15:0] i_x,
  output logic        o_valid,
  output logic [15:0] o_prob,
  output logic        o_sat,
  output logic [15:0] o_x_byp
);

  // S0: raw input capture
  logic        s0_valid_q;
  logic [15:0] s0_x_q;
  logic [15:0] s0_l_q;

  // S1: exponent and zero-sum flag
  logic        s1_valid_q;
  logic        s1_zs_q;
  logic [19:0] s1_e_q;
  logic [15:0] s1_x_q;

  // S2: final result, drives outputs directly
  logic        s2_valid_q;
  logic [15:0] s2_prob_q;
  logic        s2_sat_q;
  logic [15:0] s2_x_q;

  // S0 -> S1 combinational signals
  logic signed [19:0] xs;
  logic signed [19:0] ls;
  logic signed [19:0] t;
  logic        [19:0] e_d;
  logic               zs_d;

  // S1 -> S2 combinational signals
  logic [9:0]  f;
  logic [9:0]  neg_n;
  logic [15:0] m;
  logic [15:0] prob_d;
  logic        sat_d;

  // Exponent: x scaled by 1.4375 (~log2(e)) via shift-add, minus log2(sum)
  always_comb begin
    xs   = {{4{s0_x_q[15]}}, s0_x_q};
    ls   = {{4{s0_l_q[15]}}, s0_l_q};
    t    = xs + (xs >>> 1) - (xs >>> 4);
    e_d  = t - ls;
    zs_d = (s0_l_q == 16'h8000);
  end

  // Mitchell 2^e: mantissa 1.f shifted right by -floor(e), with clamps
  always_comb begin
    f      = s1_e_q[9:0];
    // -n as unsigned; only meaningful when e is negative (n <= -1)
    neg_n  = ~s1_e_q[19:10] + 10'd1;
    m      = {1'b1, f, 5'b0};
    prob_d = 16'h0000;
    sat_d  = 1'b0;
    if (s1_zs_q) begin
      prob_d = 16'h0000;
      sat_d  = 1'b0;
    end else if (!s1_e_q[19]) begin
      prob_d = 16'h8000;
      sat_d  = 1'b1;
    end else if (neg_n >= 10'd16) begin
      prob_d = 16'h0000;
      sat_d  = 1'b0;
    end else begin
      prob_d = m >> neg_n[3:0];
      sat_d  = 1'b0;
    end
  end

  // S0 register: capture inputs on enabled edges
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s0_valid_q <= 1'b0;
      s0_x_q     <= 16'h0000;
      s0_l_q     <= 16'h0000;
    end else if (i_en) begin
      s0_valid_q <= i_valid;
      s0_x_q     <= i_x;
      s0_l_q     <= i_log2_sum;
    end
  end

  // S1 register: exponent stage
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_zs_q    <= 1'b0;
      s1_e_q     <= 20'h00000;
      s1_x_q     <= 16'h0000;
    end else if (i_en) begin
      s1_valid_q <= s0_valid_q;
      s1_zs_q    <= zs_d;
      s1_e_q     <= e_d;
      s1_x_q     <= s0_x_q;
    end
  end

  // S2 register: result stage
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid_q <= 1'b0;
      s2_prob_q  <= 16'h0000;
      s2_sat_q   <= 1'b0;
      s2_x_q     <= 16'h0000;
    end else if (i_en) begin
      s2_valid_q <= s1_valid_q;
      s2_prob_q  <= prob_d;
      s2_sat_q   <= sat_d;
      s2_x_q     <= s1_x_q;
    end
  end

  assign o_valid = s2_valid_q;
  assign o_prob  = s2_prob_q;
  assign o_sat   = s2_sat_q;
  assign o_x_byp = s2_x_q;

endmodule

// File: tb/tb_stage2_pow2_approx.sv
// Directed bench for stage2_pow2_approx: vector table with hand-computed
// results, plus stall/bubble and mid-stream reset sequences.
module tb_stage2_pow2_approx;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        valid;
  logic [15:0] log2_sum;
  logic [15:0] x;
  logic        o_valid;
  logic [15:0] o_prob;
  logic        o_sat;
  logic [15:0] o_x_byp;

  int checks;
  int failures;

  typedef struct {
    string       name;
    logic [15:0] x;
    logic [15:0] l;
    logic [15:0] prob;
    logic        sat;
  } vec_t;

  vec_t vecs[12];

  stage2_pow2_approx dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_valid    (valid),
    .i_log2_sum (log2_sum),
    .i_x        (x),
    .o_valid    (o_valid),
    .o_prob     (o_prob),
    .o_sat      (o_sat),
    .o_x_byp    (o_x_byp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] xi, input logic [15:0] li);
    valid    = v;
    x        = xi;
    log2_sum = li;
  endtask

  task automatic chk(input string name, input logic v, input logic [15:0] p, input logic s,
                     input logic [15:0] xb);
    checks++;
    if (o_valid !== v || o_prob !== p || o_sat !== s || o_x_byp !== xb) begin
      failures++;
      $display("FAIL %s: got v=%0b p=%h s=%0b x=%h, want v=%0b p=%h s=%0b x=%h", name,
               o_valid, o_prob, o_sat, o_x_byp, v, p, s, xb);
    end
  endtask

  task automatic chk_v(input string name, input logic v);
    checks++;
    if (o_valid !== v) begin
      failures++;
      $display("FAIL %s: got o_valid=%0b, want %0b", name, o_valid, v);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    vecs[0]  = '{"one_sat",     16'h0000, 16'h0000, 16'h8000, 1'b1};
    vecs[1]  = '{"pow2_m1",     16'h0000, 16'h0400, 16'h4000, 1'b0};
    vecs[2]  = '{"mitchell",    16'hFC00, 16'h0000, 16'h3200, 1'b0};
    vecs[3]  = '{"underflow",   16'h8000, 16'h0000, 16'h0000, 1'b0};
    vecs[4]  = '{"zero_sum",    16'h0000, 16'h8000, 16'h0000, 1'b0};
    vecs[5]  = '{"half",        16'h0000, 16'h0200, 16'h6000, 1'b0};
    vecs[6]  = '{"pos_e_sat",   16'h0000, 16'hFC00, 16'h8000, 1'b1};
    vecs[7]  = '{"shift15",     16'h0000, 16'h3C00, 16'h0001, 1'b0};
    vecs[8]  = '{"shift16",     16'h0000, 16'h4000, 16'h0000, 1'b0};
    vecs[9]  = '{"x_m_half",    16'hFE00, 16'h0000, 16'h5200, 1'b0};
    vecs[10] = '{"x_m_lsb",     16'hFFFF, 16'h0000, 16'h7FF0, 1'b0};
    vecs[11] = '{"zs_neg_x",    16'hFC00, 16'h8000, 16'h0000, 1'b0};

    rst_n = 1'b1;
    en    = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000);
    #2 rst_n = 1'b0;
    #1 chk("reset_state", 1'b0, 16'h0000, 1'b0, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;

    // Table: capture, replace with junk bubble, check empty slot then result
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vecs[i].x, vecs[i].l);
      tick();
      drive(1'b0, 16'h5A5A, 16'h1234);
      tick();
      chk_v({vecs[i].name, "_early"}, 1'b0);
      tick();
      chk(vecs[i].name, 1'b1, vecs[i].prob, vecs[i].sat, vecs[i].x);
    end

    // Stall and bubbles: A(v) B(bubble) C(v) D(v) with a 2-cycle en drop
    drive(1'b1, 16'h0000, 16'h0000);
    tick();
    drive(1'b0, 16'h0000, 16'h0400);
    tick();
    drive(1'b1, 16'hFC00, 16'h0000);
    tick();
    chk("stall_a", 1'b1, 16'h8000, 1'b1, 16'h0000);
    en = 1'b0;
    drive(1'b1, 16'h7777, 16'h7777);
    tick();
    chk("stall_hold1", 1'b1, 16'h8000, 1'b1, 16'h0000);
    tick();
    chk("stall_hold2", 1'b1, 16'h8000, 1'b1, 16'h0000);
    en = 1'b1;
    drive(1'b1, 16'h8000, 16'h0000);
    tick();
    chk("stall_b_bubble", 1'b0, 16'h4000, 1'b0, 16'h0000);
    drive(1'b0, 16'h0000, 16'h0000);
    tick();
    chk("stall_c", 1'b1, 16'h3200, 1'b0, 16'hFC00);
    tick();
    chk("stall_d", 1'b1, 16'h0000, 1'b0, 16'h8000);
    tick();
    chk_v("stall_flush", 1'b0);

    // Mid-stream reset with three valid samples in flight
    drive(1'b1, 16'h0000, 16'h0000);
    tick();
    drive(1'b1, 16'h0000, 16'h0400);
    tick();
    drive(1'b1, 16'hFC00, 16'h0000);
    tick();
    chk("pre_reset_full", 1'b1, 16'h8000, 1'b1, 16'h0000);
    #2 rst_n = 1'b0;
    #1 chk("reset_async", 1'b0, 16'h0000, 1'b0, 16'h0000);
    tick();
    chk("reset_beats_en", 1'b0, 16'h0000, 1'b0, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 16'h0000, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_v("no_stale_valid", 1'b0);
    end
    drive(1'b1, 16'hFC00, 16'h0000);
    tick();
    drive(1'b0, 16'h0000, 16'h0000);
    chk_v("post_reset_lat1", 1'b0);
    tick();
    chk_v("post_reset_lat2", 1'b0);
    tick();
    chk("post_reset_lat3", 1'b1, 16'h3200, 1'b0, 16'hFC00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
